fir_filter_tdm: RTL and testbench
=================================

# fir_filter_tdm

Time-multiplexed, multi-channel successor to the systolic tap-chain FIR. One shared MAC evaluates a FIR_DEPTH-tap filter over a per-channel circular sample history. Coefficients are runtime-loadable and shared by all channels. The output is rounded and saturated back to DATA_WIDTH, and the block sits on the audio sample path wherever a fully parallel tap chain costs too many multipliers.

## Interface
- DATA_WIDTH, 24, signed sample width in and out
- COEF_WIDTH, 18, signed coefficient width
- FIR_DEPTH, 32, taps per channel (≥2)
- NUM_CH, 2, independent channels (≥1)
- FRAC_BITS, 17, coefficient fractional bits (1 ≤ FRAC_BITS < COEF_WIDTH)
- Derived: CW = max(1,clog2(NUM_CH)), AW = clog2(FIR_DEPTH), ACC_WIDTH = DATA_WIDTH+COEF_WIDTH+AW
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  global clock enable; low = all state and outputs hold
- i_din_valid  in  1  input sample present
- o_din_ready  out  1  combinational: (state==IDLE) && i_en
- iv_din  in  DATA_WIDTH  signed input sample
- iv_din_ch  in  CW  channel of iv_din
- i_coef_we  in  1  coefficient write strobe
- iv_coef_addr  in  AW  tap index k
- iv_coef_data  in  COEF_WIDTH  signed coefficient h[k]
- o_coef_err  out  1  one-cycle pulse: coefficient write dropped
- ov_dout  out  DATA_WIDTH  signed filtered sample
- ov_dout_ch  out  CW  channel of ov_dout
- o_dout_valid  out  1  one-cycle pulse: ov_dout/ov_dout_ch valid
- o_sat  out  1  qualifies o_dout_valid: result was clipped

## Operation
- Reset values:
  - state IDLE.
  - All history, all coefficients and all per-channel write pointers are 0.
  - ov_dout=0, ov_dout_ch=0, o_dout_valid=0, o_sat=0, o_coef_err=0.
- Handshake: a sample is accepted when i_din_valid && o_din_ready.
  - iv_din is written to hist[ch][wptr[ch]].
  - The newest-sample pointer is latched and wptr[ch] increments modulo FIR_DEPTH (wraps FIR_DEPTH-1→0).
- Channel out of range (iv_din_ch ≥ NUM_CH): the handshake completes, the sample is discarded, state stays IDLE and no output is produced.
- FSM:
  - IDLE→MAC on accept.
  - MAC runs k=0..FIR_DEPTH-1, one tap per cycle: acc += h[k]·x[n−k]. The history read address is (newest − k) mod FIR_DEPTH.
  - MAC→DONE after k=FIR_DEPTH-1.
  - DONE→IDLE unconditionally.
- Accumulator:
  - Cleared on accept.
  - Product is full-precision signed DATA_WIDTH+COEF_WIDTH, sign-extended to ACC_WIDTH.
  - No internal overflow is possible.
- DONE: r = (acc + 2^(FRAC_BITS−1)) >>> FRAC_BITS (round half toward +∞), then saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - ov_dout, ov_dout_ch and o_sat are registered.
  - o_dout_valid=1 for the following cycle.
- Outputs ov_dout and ov_dout_ch hold their value until the next result.
- Coefficients:
  - A write with i_coef_we=1 takes effect only when state==IDLE && i_en.
  - A write while busy is dropped and o_coef_err pulses the next cycle.
  - A write and a sample accept in the same IDLE cycle: the write lands first, so the new coefficient is used for that sample.
- i_en=0: the FSM, accumulator, pointers and every output register hold, including a pending o_dout_valid pulse, which stretches. Downstream qualifies with i_en.
- Histories are fully independent per channel. A sample on channel c never reads another channel's history.

## Timing
- Accept at cycle T.
- MAC for k=0..FIR_DEPTH-1 occupies T+1..T+FIR_DEPTH.
- DONE occupies T+FIR_DEPTH+1.
- o_dout_valid is high in T+FIR_DEPTH+2 (latency FIR_DEPTH+2, i_en held high).
- o_din_ready is low for T+1..T+FIR_DEPTH+1 and high again at T+FIR_DEPTH+2. Maximum throughput is one sample per FIR_DEPTH+2 cycles across all channels.
- Reset asserted mid-MAC: all outputs drop to reset values immediately (asynchronous), no result is emitted, and history and coefficients are cleared.
- After reset deassert, o_din_ready=1 from the first clock edge with i_en=1.
- o_coef_err, o_dout_valid and o_sat are registered. Only o_din_ready is combinational.

## Test plan
- Impulse response:
  - Stimulus: h[0]=65536 (0.5), h[1]=−32768 (−0.25), other taps 0; ch0 input 1000 then zeros.
  - Required: ch0 outputs 500, −250, 0, 0…
  - Required: each valid exactly FIR_DEPTH+2=34 cycles after its accept, and o_din_ready low for 33 cycles.
- Rounding:
  - Stimulus: h[0]=65536, input 3.
  - Required: output 2.
  - Stimulus: input −3.
  - Required: output −1.
  - Stimulus: input 1.
  - Required: output 1.
  - Required: o_sat=0 throughout.
- Saturation:
  - Stimulus: all 32 taps 131071; ch1 fed 8388607 repeatedly.
  - Required: once history fills, ov_dout=8388607 with o_sat=1.
  - Stimulus: then feed −8388608 repeatedly.
  - Required: once history fills, ov_dout=−8388608 with o_sat=1.
- Channel isolation and wrap:
  - Stimulus: interleave ch0 impulse 1000 with 40 ch1 zeros, then 40 ch0 zeros.
  - Required: ch1 outputs all 0.
  - Required: ch0 sequence 500, −250, then zeros through the pointer wrap past 31.
  - Stimulus: iv_din_ch=3 with NUM_CH=2.
  - Required: ready consumed and no output.
- Coefficient and enable rules:
  - Stimulus: coefficient write at MAC cycle 10.
  - Required: o_coef_err=1 next cycle and the result matches the old coefficient set.
  - Stimulus: i_en=0 for 5 cycles mid-MAC.
  - Required: latency extends by exactly 5.
- Reset mid-operation:
  - Stimulus: assert i_rst at MAC cycle 5.
  - Required: no o_dout_valid, all outputs 0 during reset, ready=1 after release.
  - Stimulus: a new input 1000 after release.
  - Required: output 0, because coefficients are cleared.

Source files
------------

// File: rtl/fir_filter_tdm.sv
`default_nettype none
// ============================================================================
// Module   : fir_filter_tdm
// Purpose  : Time-multiplexed multi-channel FIR filter. A single shared MAC
//            walks FIR_DEPTH taps over a per-channel circular sample history,
//            then rounds (half toward +inf) and saturates to DATA_WIDTH.
//            Coefficients are runtime-loadable and shared by all channels.
// Ports    : i_clk, i_rst (async, active-high), i_en (global clock enable)
//            i_din_valid / o_din_ready / iv_din / iv_din_ch : sample input
//            i_coef_we / iv_coef_addr / iv_coef_data        : coefficient load
//            o_coef_err   : pulse, coefficient write dropped (block busy)
//            ov_dout / ov_dout_ch / o_dout_valid / o_sat   : filtered output
// Revision : 1.0 - initial release
// ============================================================================
module fir_filter_tdm #(
  parameter  int DATA_WIDTH = 24,
  parameter  int COEF_WIDTH = 18,
  parameter  int FIR_DEPTH  = 32,
  parameter  int NUM_CH     = 2,
  parameter  int FRAC_BITS  = 17,
  localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW         = $clog2(FIR_DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_din_valid,
  output logic                         o_din_ready,
  input  logic signed [DATA_WIDTH-1:0] iv_din,
  input  logic        [CW-1:0]         iv_din_ch,
  input  logic                         i_coef_we,
  input  logic        [AW-1:0]         iv_coef_addr,
  input  logic signed [COEF_WIDTH-1:0] iv_coef_data,
  output logic                         o_coef_err,
  output logic signed [DATA_WIDTH-1:0] ov_dout,
  output logic        [CW-1:0]         ov_dout_ch,
  output logic                         o_dout_valid,
  output logic                         o_sat
);

  localparam int PW        = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_WIDTH = PW + AW;
  localparam logic [AW-1:0] LAST_TAP = AW'(FIR_DEPTH - 1);
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH-1:0] DMAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DMIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] hist [NUM_CH][FIR_DEPTH];
  logic signed [COEF_WIDTH-1:0] coef [FIR_DEPTH];
  logic        [AW-1:0]         wptr [NUM_CH];
  logic        [AW-1:0]         newest;
  logic        [AW-1:0]         tap;
  logic        [CW-1:0]         cur_ch;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic                         accept;
  logic                         ch_ok;
  logic                         coef_ok;
  logic                         coef_wr;
  logic                         take;
  logic        [AW-1:0]         rd_addr;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  rnd_sum;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [DATA_WIDTH-1:0] sat_val;
  logic                         sat_hit;

  assign o_din_ready = (state == S_IDLE) && i_en;
  assign accept      = i_din_valid && o_din_ready;
  // Out-of-range channels complete the handshake but are otherwise ignored.
  assign ch_ok       = {1'b0, iv_din_ch} < (CW+1)'(NUM_CH);
  assign take        = accept && ch_ok;
  assign coef_ok     = {1'b0, iv_coef_addr} < (AW+1)'(FIR_DEPTH);
  assign coef_wr     = i_coef_we && (state == S_IDLE) && i_en && coef_ok;

  // x[n-k] lives at (newest - k) mod FIR_DEPTH; explicit wrap keeps this
  // correct for non-power-of-two depths.
  always_comb begin
    rd_addr = newest - tap;
    if (tap > newest) begin
      rd_addr = AW'({1'b0, newest} + (AW+1)'(FIR_DEPTH) - {1'b0, tap});
    end
  end

  assign prod    = coef[tap] * hist[cur_ch][rd_addr];
  assign rnd_sum = acc + RND_HALF;
  assign shifted = rnd_sum >>> FRAC_BITS;

  always_comb begin
    sat_val = shifted[DATA_WIDTH-1:0];
    sat_hit = 1'b0;
    if (shifted > DMAX) begin
      sat_val = DMAX[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end else if (shifted < DMIN) begin
      sat_val = DMIN[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else if (i_en) begin
      state <= state_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take) state_nxt = S_MAC;
      S_MAC:   if (tap == LAST_TAP) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sample histories, write pointers and coefficient store
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        for (int k = 0; k < FIR_DEPTH; k++) begin
          hist[c][k] <= '0;
        end
      end
      for (int k = 0; k < FIR_DEPTH; k++) begin
        coef[k] <= '0;
      end
    end else begin
      if (take) begin
        hist[iv_din_ch][wptr[iv_din_ch]] <= iv_din;
        wptr[iv_din_ch] <= (wptr[iv_din_ch] == LAST_TAP) ? '0 : wptr[iv_din_ch] + AW'(1);
      end
      // Registered write is visible from the next cycle, i.e. before the
      // first MAC cycle of a sample accepted in the same cycle.
      if (coef_wr) begin
        coef[iv_coef_addr] <= iv_coef_data;
      end
    end
  end

  // MAC datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      newest <= '0;
      cur_ch <= '0;
      tap    <= '0;
      acc    <= '0;
    end else if (i_en) begin
      if (take) begin
        newest <= wptr[iv_din_ch];
        cur_ch <= iv_din_ch;
        tap    <= '0;
        acc    <= '0;
      end else if (state == S_MAC) begin
        acc <= acc + {{AW{prod[PW-1]}}, prod};
        tap <= tap + AW'(1);
      end
    end
  end

  // Output registers; everything holds while i_en is low, so a pending
  // valid pulse stretches until the enable returns.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_dout      <= '0;
      ov_dout_ch   <= '0;
      o_dout_valid <= 1'b0;
      o_sat        <= 1'b0;
      o_coef_err   <= 1'b0;
    end else if (i_en) begin
      o_dout_valid <= (state == S_DONE);
      o_coef_err   <= i_coef_we && (state != S_IDLE);
      if (state == S_DONE) begin
        ov_dout    <= sat_val;
        ov_dout_ch <= cur_ch;
        o_sat      <= sat_hit;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_filter_tdm
// Purpose  : Self-checking bench for fir_filter_tdm. A behavioural model
//            (shift-register history, direct convolution) feeds a scoreboard
//            queue at every accepted sample; a monitor pops and compares on
//            every output. Scenario tasks add their own inline checks.
//            NUM_CH is 3 here so that channel code 3 is representable and
//            out of range (two channels give a one-bit channel field).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_filter_tdm;

  localparam int DW  = 24;
  localparam int CWD = 18;
  localparam int D   = 32;
  localparam int NCH = 3;
  localparam int FB  = 17;
  localparam int CW  = 2;
  localparam int AW  = 5;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  din_valid;
  logic                  din_ready;
  logic signed [DW-1:0]  din;
  logic        [CW-1:0]  din_ch;
  logic                  coef_we;
  logic        [AW-1:0]  coef_addr;
  logic signed [CWD-1:0] coef_data;
  logic                  coef_err;
  logic signed [DW-1:0]  dout;
  logic        [CW-1:0]  dout_ch;
  logic                  dout_valid;
  logic                  sat;

  fir_filter_tdm #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CWD), .FIR_DEPTH(D), .NUM_CH(NCH), .FRAC_BITS(FB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_din_valid(din_valid), .o_din_ready(din_ready), .iv_din(din), .iv_din_ch(din_ch),
    .i_coef_we(coef_we), .iv_coef_addr(coef_addr), .iv_coef_data(coef_data),
    .o_coef_err(coef_err),
    .ov_dout(dout), .ov_dout_ch(dout_ch), .o_dout_valid(dout_valid), .o_sat(sat)
  );

  typedef struct packed {
    logic signed [DW-1:0] dout;
    logic        [CW-1:0] ch;
    logic                 sat;
  } res_t;

  res_t   sb[$];
  res_t   obs[$];
  longint coef_m [D];
  longint hist_m [NCH][D];
  int     n_pass;
  int     n_total;
  int     cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int k = 0; k < D; k++) begin
      coef_m[k] = 0;
      for (int c = 0; c < NCH; c++) hist_m[c][k] = 0;
    end
  endfunction

  // Newest sample at index 0, so tap k multiplies hist_m[c][k] directly.
  function automatic res_t model_step(input int c, input longint x);
    longint acc;
    longint r;
    res_t   e;
    for (int k = D - 1; k > 0; k--) hist_m[c][k] = hist_m[c][k-1];
    hist_m[c][0] = x;
    acc = 0;
    for (int k = 0; k < D; k++) acc += coef_m[k] * hist_m[c][k];
    r = (acc + (longint'(1) << (FB - 1))) >>> FB;
    e.sat = 1'b0;
    if (r > 8388607) begin
      r = 8388607;
      e.sat = 1'b1;
    end else if (r < -8388608) begin
      r = -8388608;
      e.sat = 1'b1;
    end
    e.dout = r[DW-1:0];
    e.ch   = c[CW-1:0];
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    res_t got;
    res_t e;
    if (!rst && dout_valid && en) begin
      got.dout = dout;
      got.ch   = dout_ch;
      got.sat  = sat;
      obs.push_back(got);
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got dout=%0d ch=%0d sat=%0d, required no output",
                 got.dout, got.ch, got.sat);
      end else begin
        e = sb.pop_front();
        if (got !== e)
          $display("FAIL sb_result: got dout=%0d ch=%0d sat=%0d, required dout=%0d ch=%0d sat=%0d",
                   got.dout, got.ch, got.sat, e.dout, e.ch, e.sat);
        else
          n_pass++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    coef_we = 1'b0;
    sb.delete();
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int w;
    w = 0;
    while (!din_ready && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    ok = din_ready;
    if (!ok) begin
      n_total++;
      $display("FAIL ready_timeout: o_din_ready=%0d after %0d cycles, required 1", din_ready, w);
    end
  endtask

  task automatic write_coef(input int a, input int v);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      coef_we   = 1'b1;
      coef_addr = a[AW-1:0];
      coef_data = v[CWD-1:0];
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      coef_m[a] = v;
    end
  endtask

  task automatic send(input int c, input longint x, output int t_acc);
    bit ok;
    wait_ready(ok);
    t_acc = -1;
    if (ok) begin
      din_valid = 1'b1;
      din       = x[DW-1:0];
      din_ch    = c[CW-1:0];
      t_acc     = cyc;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      if (c < NCH) sb.push_back(model_step(c, x));
    end
  endtask

  task automatic wait_valid(output int t);
    int w;
    w = 0;
    t = -1;
    while (w < 200) begin
      @(negedge clk);
      if (dout_valid && en) begin
        t = cyc;
        break;
      end
      w++;
    end
    if (t < 0) begin
      n_total++;
      $display("FAIL valid_timeout: no o_dout_valid within %0d cycles, required one", w);
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic set_basic_coefs();
    write_coef(0, 65536);
    write_coef(1, -32768);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total += 6;
    if (dout !== 0) $display("FAIL reset_dout: got %0d, required 0", dout); else n_pass++;
    if (dout_ch !== 0) $display("FAIL reset_dout_ch: got %0d, required 0", dout_ch); else n_pass++;
    if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %0b, required 0", dout_valid); else n_pass++;
    if (sat !== 1'b0) $display("FAIL reset_sat: got %0b, required 0", sat); else n_pass++;
    if (coef_err !== 1'b0) $display("FAIL reset_coef_err: got %0b, required 0", coef_err); else n_pass++;
    if (din_ready !== 1'b1) $display("FAIL reset_ready: got %0b, required 1", din_ready); else n_pass++;
  endtask

  task automatic test_impulse();
    int exp_v [4] = '{500, -250, 0, 0};
    int t_acc;
    int t_out;
    int low;
    set_basic_coefs();
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 0) ? 1000 : 0, t_acc);
      low = 0;
      t_out = -1;
      for (int w = 0; w < 200; w++) begin
        @(negedge clk);
        if (!din_ready) low++;
        if (dout_valid) begin
          t_out = cyc;
          break;
        end
      end
      n_total += 3;
      if (t_out - t_acc !== D + 2)
        $display("FAIL impulse_latency[%0d]: got %0d, required %0d", i, t_out - t_acc, D + 2);
      else n_pass++;
      if (low !== D + 1)
        $display("FAIL impulse_ready_low[%0d]: got %0d cycles, required %0d", i, low, D + 1);
      else n_pass++;
      if (dout !== exp_v[i][DW-1:0])
        $display("FAIL impulse_value[%0d]: got %0d, required %0d", i, dout, exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rounding();
    int in_v  [3] = '{3, -3, 1};
    int exp_v [3] = '{2, -1, 1};
    int t_acc;
    int t_out;
    write_coef(1, 0);
    for (int i = 0; i < 3; i++) begin
      send(0, in_v[i], t_acc);
      wait_valid(t_out);
      n_total += 2;
      if (dout !== exp_v[i][DW-1:0])
        $display("FAIL round_value[%0d]: got %0d, required %0d", i, dout, exp_v[i]);
      else n_pass++;
      if (sat !== 1'b0) $display("FAIL round_sat[%0d]: got %0b, required 0", i, sat); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    longint lvl [2] = '{8388607, -8388608};
    int t_acc;
    res_t last;
    for (int k = 0; k < D; k++) write_coef(k, 131071);
    for (int p = 0; p < 2; p++) begin
      obs.delete();
      for (int i = 0; i < D; i++) send(1, lvl[p], t_acc);
      wait_drain();
      n_total++;
      if (obs.size() == 0) begin
        $display("FAIL sat_no_output[%0d]: got 0 results, required %0d", p, D);
      end else begin
        last = obs[obs.size() - 1];
        if (last.dout !== lvl[p][DW-1:0] || last.sat !== 1'b1 || last.ch !== 2'd1)
          $display("FAIL sat_value[%0d]: got dout=%0d sat=%0b ch=%0d, required dout=%0d sat=1 ch=1",
                   p, last.dout, last.sat, last.ch, lvl[p]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_channels();
    int t_acc;
    int n0, n1, nz0, nz1, v0, v1, w;
    do_reset();
    set_basic_coefs();
    obs.delete();
    send(0, 1000, t_acc);
    for (int i = 0; i < 40; i++) send(1, 0, t_acc);
    for (int i = 0; i < 40; i++) send(0, 0, t_acc);
    wait_drain();
    n0 = 0; n1 = 0; nz0 = 0; nz1 = 0; v0 = 0; v1 = 0;
    foreach (obs[i]) begin
      if (obs[i].ch == 2'd1) begin
        n1++;
        if (obs[i].dout != 0) nz1++;
      end else begin
        if (n0 == 0) v0 = obs[i].dout;
        else if (n0 == 1) v1 = obs[i].dout;
        else if (obs[i].dout != 0) nz0++;
        n0++;
      end
    end
    n_total += 4;
    if (n1 !== 40 || nz1 !== 0)
      $display("FAIL chan_ch1: got %0d results with %0d nonzero, required 40 with 0 nonzero", n1, nz1);
    else n_pass++;
    if (n0 !== 41) $display("FAIL chan_ch0_count: got %0d, required 41", n0); else n_pass++;
    if (v0 !== 500 || v1 !== -250)
      $display("FAIL chan_ch0_head: got %0d,%0d, required 500,-250", v0, v1);
    else n_pass++;
    if (nz0 !== 0) $display("FAIL chan_ch0_tail: got %0d nonzero, required 0", nz0); else n_pass++;

    // Out-of-range channel: accepted, discarded, no result.
    send(3, 777, t_acc);
    n_total++;
    if (t_acc < 0 || din_ready !== 1'b1)
      $display("FAIL chan_bad_ready: got accept=%0d ready_after=%0b, required accepted and 1",
               t_acc >= 0, din_ready);
    else n_pass++;
    w = 0;
    for (int i = 0; i < D + 8; i++) begin
      @(negedge clk);
      if (dout_valid) w++;
    end
    n_total++;
    if (w !== 0) $display("FAIL chan_bad_output: got %0d valid pulses, required 0", w); else n_pass++;
    send(0, 5, t_acc);
    wait_drain();
  endtask

  task automatic test_coef_enable();
    int t_acc;
    int t_out;
    do_reset();
    set_basic_coefs();
    send(0, 1000, t_acc);
    repeat (9) @(posedge clk);
    #1;
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = 18'sd12345;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    @(negedge clk);
    n_total++;
    if (coef_err !== 1'b1) $display("FAIL coef_err_pulse: got %0b, required 1", coef_err); else n_pass++;
    @(negedge clk);
    n_total++;
    if (coef_err !== 1'b0) $display("FAIL coef_err_clear: got %0b, required 0", coef_err); else n_pass++;
    wait_valid(t_out);
    n_total++;
    if (dout !== 500) $display("FAIL coef_old_set: got %0d, required 500", dout); else n_pass++;

    send(0, 0, t_acc);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b1;
    wait_valid(t_out);
    n_total += 2;
    if (t_out - t_acc !== D + 2 + 5)
      $display("FAIL enable_latency: got %0d, required %0d", t_out - t_acc, D + 7);
    else n_pass++;
    if (dout !== -250) $display("FAIL enable_value: got %0d, required -250", dout); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t_acc;
    int t_out;
    int w;
    do_reset();
    set_basic_coefs();
    send(0, 1000, t_acc);
    wait_valid(t_out);
    send(0, 0, t_acc);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    model_clear();
    #1;
    n_total += 5;
    if (dout !== 0) $display("FAIL rstmid_dout: got %0d, required 0", dout); else n_pass++;
    if (dout_ch !== 0) $display("FAIL rstmid_ch: got %0d, required 0", dout_ch); else n_pass++;
    if (dout_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b, required 0", dout_valid); else n_pass++;
    if (sat !== 1'b0) $display("FAIL rstmid_sat: got %0b, required 0", sat); else n_pass++;
    if (coef_err !== 1'b0) $display("FAIL rstmid_coef_err: got %0b, required 0", coef_err); else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (din_ready !== 1'b1) $display("FAIL rstmid_ready: got %0b, required 1", din_ready); else n_pass++;
    w = 0;
    for (int i = 0; i < D + 8; i++) begin
      @(negedge clk);
      if (dout_valid) w++;
    end
    n_total++;
    if (w !== 0) $display("FAIL rstmid_no_result: got %0d valid pulses, required 0", w); else n_pass++;
    send(0, 1000, t_acc);
    wait_valid(t_out);
    n_total++;
    if (dout !== 0) $display("FAIL rstmid_cleared_coefs: got %0d, required 0", dout); else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    cyc       = 0;
    rst       = 1'b1;
    en        = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    din_ch    = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_clear();

    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_channels();
    test_coef_enable();
    test_reset_mid();
    wait_drain();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
